// File: rtl/imem_pkg.sv
// Shared definitions for the loadable instruction memory: load-FSM encoding and ARM constants.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ld_state_e;

  localparam logic [31:0] ARM_NOP       = 32'hE1A0_0000;
  // BAL to self: a fetching core spins in place until real code is present.
  localparam logic [31:0] ARM_BAL_SELF  = 32'hEAFF_FFFE;
  localparam logic [31:0] FILL_WORD_DEF = ARM_BAL_SELF;

endpackage

// File: rtl/imem_load_ctrl.sv
// Program-load controller: accepts ld_count words from a valid/ready stream and
// produces the write strobe and word index for the memory array.
module imem_load_ctrl
  import imem_pkg::*;
#(
  parameter int ADDR_BITS = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ld_start,
  input  logic [ADDR_BITS-1:0] ld_base,
  input  logic [ADDR_BITS:0]   ld_count,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] wr_idx
);

  localparam logic [ADDR_BITS:0] LP_DEPTH = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0] LP_ONE   = {{ADDR_BITS{1'b0}}, 1'b1};

  ld_state_e            r_state, w_state_nxt;
  logic [ADDR_BITS-1:0] r_ptr, w_ptr_nxt;
  logic [ADDR_BITS:0]   r_rem, w_rem_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_rem_nxt   = r_rem;
    ld_ready    = 1'b0;
    done        = 1'b0;
    wr_en       = 1'b0;
    case (r_state)
      IDLE: begin
        if (ld_start) begin
          if (ld_count == '0) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = LOAD;
            w_ptr_nxt   = ld_base;
            w_rem_nxt   = (ld_count > LP_DEPTH) ? LP_DEPTH : ld_count;
          end
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          wr_en     = 1'b1;
          // Pointer is exactly ADDR_BITS wide, so it wraps from DEPTH-1 to 0.
          w_ptr_nxt = r_ptr + 1'b1;
          w_rem_nxt = r_rem - LP_ONE;
          if (r_rem == LP_ONE) begin
            w_state_nxt = DONE;
          end
        end
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign wr_idx = r_ptr;
  assign busy   = (r_state != IDLE);

endmodule

// File: rtl/imem_loadable.sv
// Loadable instruction memory: byte-addressed fetch read port, word-serial load port.
// Never-written or out-of-range words read as FILL_WORD; optional registered read.
module imem_loadable
  import imem_pkg::*;
#(
  parameter int                ADDR_BITS = 6,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(FILL_WORD_DEF),
  parameter int                READ_REG  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          A,
  output logic [DATA_W-1:0]    RD,
  input  logic                 ld_start,
  input  logic [ADDR_BITS-1:0] ld_base,
  input  logic [ADDR_BITS:0]   ld_count,
  input  logic                 ld_valid,
  input  logic [DATA_W-1:0]    ld_data,
  output logic                 ld_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_W-1:0]    r_mem [DEPTH];
  logic [DEPTH-1:0]     r_valid;
  logic                 w_wr_en;
  logic [ADDR_BITS-1:0] w_wr_idx;
  logic [ADDR_BITS-1:0] w_rd_idx;
  logic                 w_in_range;
  logic [DATA_W-1:0]    w_rd;
  logic                 w_unused_a;

  imem_load_ctrl #(
    .ADDR_BITS(ADDR_BITS)
  ) u_ctrl (
    .clk     (clk),
    .reset   (reset),
    .ld_start(ld_start),
    .ld_base (ld_base),
    .ld_count(ld_count),
    .ld_valid(ld_valid),
    .ld_ready(ld_ready),
    .busy    (busy),
    .done    (done),
    .wr_en   (w_wr_en),
    .wr_idx  (w_wr_idx)
  );

  // Data array is deliberately unreset; the valid bits alone decide visibility.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= ld_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
    end else if (w_wr_en) begin
      r_valid[w_wr_idx] <= 1'b1;
    end
  end

  assign w_rd_idx   = A[ADDR_BITS+1:2];
  assign w_in_range = ((A >> (ADDR_BITS + 2)) == 32'd0);
  assign w_rd       = (w_in_range && r_valid[w_rd_idx]) ? r_mem[w_rd_idx] : FILL_WORD;
  assign w_unused_a = ^A[1:0];

  generate
    if (READ_REG != 0) begin : g_rd_reg
      logic [DATA_W-1:0] r_rd;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_rd <= FILL_WORD;
        end else begin
          r_rd <= w_rd;
        end
      end
      assign RD = r_rd;
    end else begin : g_rd_comb
      assign RD = w_rd;
    end
  endgenerate

endmodule
